delay_responder: RTL and testbench



---
 rtl/delay_resp_pkg.sv | 40 ++++
 rtl/delay_slot.sv | 54 +++++
 rtl/delay_responder.sv | 122 ++++++++++++
 tb/tb_delay_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_resp_pkg.sv
// delay_resp_pkg
// Shared definitions for the delay_responder block: default parameter
// values, width helpers, the slot record layout and the slot allocator
// helper used by the top level.
package delay_resp_pkg;

  localparam int MAX_DELAY_DEF       = 8;
  localparam int MAX_OUTSTANDING_DEF = 4;
  localparam int DEFAULT_DELAY_DEF   = 2;

  // Width of a delay value able to hold 0..max_delay.
  function automatic int dly_width(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

  // Width of a slot down-counter; a slot never holds more than max_delay-1.
  // Kept at least one bit wide so a MAX_DELAY of 1 still elaborates.
  function automatic int cnt_width(input int max_delay);
    return (max_delay > 1) ? $clog2(max_delay) : 1;
  endfunction

  localparam int DLY_W = dly_width(MAX_DELAY_DEF);
  localparam int CNT_W = cnt_width(MAX_DELAY_DEF);

  typedef struct packed {
    logic             valid;
    logic [CNT_W-1:0] count;
  } slot_t;

  // Index of the lowest set bit among the first n bits, or -1 if none.
  function automatic int lowest_free(input logic [31:0] free_vec, input int n);
    int idx;
    idx = -1;
    for (int i = n - 1; i >= 0; i--) begin
      if (free_vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/delay_slot.sv
// delay_slot
// One countdown slot of the responder. A load captures the remaining
// delay; the slot then counts down each edge and reports maturity when
// its count reaches 1, freeing itself on that same edge.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : occupy the slot with load_cnt (wins over maturity)
//   load_cnt   : remaining edges until maturity (>= 1)
//   valid      : slot occupied
//   mature     : slot finishes this edge (ack becomes due)
module delay_slot
  import delay_resp_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_cnt,
  output logic             valid,
  output logic             mature
);

  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign valid  = valid_q;
  assign mature = valid_q && (count_q == CNT_W'(1));

  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    if (load) begin
      // A maturing slot may be reloaded on the same edge.
      valid_d = 1'b1;
      count_d = load_cnt;
    end else if (mature) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  // The count is only meaningful while valid, so it needs no reset.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

endmodule

// File: rtl/delay_responder.sv
// delay_responder
// Responder side of a "req ##D ack" handshake: every sampled request
// yields one registered ack pulse D edges later. Overlapping requests
// are held in a pool of countdown slots.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   req             : request, one per edge sampled high
//   cfg_load        : load cfg_delay into the active delay
//   cfg_delay       : new delay value (1..MAX_DELAY)
//   err_clr         : clear sticky error flags
//   ack             : registered acknowledge pulse
//   busy            : any slot occupied
//   outstanding     : number of occupied slots
//   ovf_err         : sticky, a request was dropped for lack of a slot
//   cfg_err         : sticky, a configuration load was rejected
//   cur_delay       : active delay D
module delay_responder
  import delay_resp_pkg::*;
#(
  parameter int MAX_DELAY       = MAX_DELAY_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int DEFAULT_DELAY   = DEFAULT_DELAY_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               req,
  input  logic                               cfg_load,
  input  logic [$clog2(MAX_DELAY+1)-1:0]     cfg_delay,
  input  logic                               err_clr,
  output logic                               ack,
  output logic                               busy,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                               ovf_err,
  output logic                               cfg_err,
  output logic [$clog2(MAX_DELAY+1)-1:0]     cur_delay
);

  localparam int D_W = dly_width(MAX_DELAY);
  localparam int C_W = cnt_width(MAX_DELAY);
  localparam int O_W = $clog2(MAX_OUTSTANDING + 1);

  logic [MAX_OUTSTANDING-1:0] slot_valid, slot_mature, slot_load;
  logic [MAX_OUTSTANDING-1:0] free_vec, valid_next;
  logic [C_W-1:0]             load_cnt;
  int                         free_idx;
  logic                       direct, drop, cfg_ok;

  logic           ack_q, ack_d;
  logic           ovf_q, ovf_d;
  logic           cfg_err_q, cfg_err_d;
  logic [D_W-1:0] cur_delay_q, cur_delay_d;
  logic [O_W-1:0] outstanding_q, outstanding_d;

  assign ack         = ack_q;
  assign ovf_err     = ovf_q;
  assign cfg_err     = cfg_err_q;
  assign cur_delay   = cur_delay_q;
  assign outstanding = outstanding_q;
  assign busy        = (outstanding_q != '0);

  // A slot loaded with D-1 matures D-1 edges later, setting ack for edge t+D.
  assign load_cnt = C_W'(cur_delay_q - D_W'(1));

  for (genvar g = 0; g < MAX_OUTSTANDING; g++) begin : g_slot
    delay_slot #(.CNT_W(C_W)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (slot_load[g]),
      .load_cnt (load_cnt),
      .valid    (slot_valid[g]),
      .mature   (slot_mature[g])
    );
  end

  always_comb begin
    // A maturing slot counts as free, so it can be reused on this edge.
    free_vec = ~slot_valid | slot_mature;
    free_idx = lowest_free(32'(free_vec), MAX_OUTSTANDING);
    // With D=1 the request bypasses the slots straight into the ack flop.
    direct   = (cur_delay_q == D_W'(1));
    drop     = req && !direct && (free_idx < 0);

    slot_load = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      slot_load[i] = req && !direct && (free_idx == i);
    end

    valid_next    = slot_load | (slot_valid & ~slot_mature);
    outstanding_d = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      outstanding_d = outstanding_d + O_W'(valid_next[i]);
    end

    ack_d = (|slot_mature) || (req && direct);

    // D may only change while nothing is in flight and no request arrives.
    cfg_ok = cfg_load && !busy && !req &&
             (cfg_delay != '0) && (cfg_delay <= D_W'(MAX_DELAY));
    cur_delay_d = cfg_ok ? cfg_delay : cur_delay_q;

    // A new error beats a simultaneous clear.
    ovf_d     = drop || (ovf_q && !err_clr);
    cfg_err_d = (cfg_load && !cfg_ok) || (cfg_err_q && !err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q         <= 1'b0;
      ovf_q         <= 1'b0;
      cfg_err_q     <= 1'b0;
      cur_delay_q   <= D_W'(DEFAULT_DELAY);
      outstanding_q <= '0;
    end else begin
      ack_q         <= ack_d;
      ovf_q         <= ovf_d;
      cfg_err_q     <= cfg_err_d;
      cur_delay_q   <= cur_delay_d;
      outstanding_q <= outstanding_d;
    end
  end

endmodule

// File: tb/tb_delay_responder.sv
// tb_delay_responder
// Self-checking bench for delay_responder: a directed vector table, a few
// hand-written multi-cycle sequences and a randomized run checked against
// a request-list reference model.
module tb_delay_responder;
  import delay_resp_pkg::*;

  localparam int MAXD = 8;
  localparam int MAXO = 4;
  localparam int DEFD = 2;
  localparam int DW   = DLY_W;
  localparam int OW   = $clog2(MAXO + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          cfg_load = 1'b0;
  logic [DW-1:0] cfg_delay = '0;
  logic          err_clr = 1'b0;
  logic          ack, busy, ovf_err, cfg_err;
  logic [OW-1:0] outstanding;
  logic [DW-1:0] cur_delay;

  delay_responder #(
    .MAX_DELAY       (MAXD),
    .MAX_OUTSTANDING (MAXO),
    .DEFAULT_DELAY   (DEFD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .cfg_load    (cfg_load),
    .cfg_delay   (cfg_delay),
    .err_clr     (err_clr),
    .ack         (ack),
    .busy        (busy),
    .outstanding (outstanding),
    .ovf_err     (ovf_err),
    .cfg_err     (cfg_err),
    .cur_delay   (cur_delay)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: list of accepted requests (edge, delay).
  typedef struct { int t; int d; } acc_t;
  acc_t acc_q[$];
  int   m_e = 0;
  int   m_cur = DEFD;
  int   m_out = 0;
  bit   m_ack = 0, m_ovf = 0, m_cerr = 0;

  typedef struct {
    bit r; bit cl; int cd; bit ec;
    bit ack; int out; bit ovf; bit cerr; int cur;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, m_e);
    end
  endtask

  task automatic model_reset();
    acc_q.delete();
    m_cur = DEFD; m_out = 0; m_ack = 0; m_ovf = 0; m_cerr = 0;
  endtask

  task automatic model_edge(input bit r, input bit cl, input int cd, input bit ec);
    int occ = 0;
    bit drop = 0;
    bit ok;
    bit busy_prev;
    m_e++;
    busy_prev = (m_out != 0);
    // A request needs a slot for edges t..t+D-2; one ending before now is free.
    foreach (acc_q[i]) if (acc_q[i].d >= 2 && acc_q[i].t + acc_q[i].d - 2 >= m_e) occ++;
    if (r) begin
      if (m_cur == 1 || occ < MAXO) acc_q.push_back('{t: m_e, d: m_cur});
      else drop = 1;
    end
    ok = cl && !busy_prev && !r && cd >= 1 && cd <= MAXD;
    m_cerr = (cl && !ok) || (m_cerr && !ec);
    m_ovf  = drop || (m_ovf && !ec);
    if (ok) m_cur = cd;
    m_ack = 0;
    m_out = 0;
    foreach (acc_q[i]) begin
      // Output after edge e is what is sampled at e+1 = t+D.
      if (acc_q[i].t + acc_q[i].d - 1 == m_e) m_ack = 1;
      if (acc_q[i].d >= 2 && acc_q[i].t <= m_e && m_e <= acc_q[i].t + acc_q[i].d - 2) m_out++;
    end
    for (int i = acc_q.size() - 1; i >= 0; i--) begin
      if (acc_q[i].t + acc_q[i].d - 1 <= m_e) acc_q.delete(i);
    end
  endtask

  task automatic step(input bit r, input bit cl, input int cd, input bit ec);
    req = r; cfg_load = cl; cfg_delay = DW'(cd); err_clr = ec;
    @(posedge clk);
    #1;
    model_edge(r, cl, cd, ec);
  endtask

  task automatic check_model();
    check("ack", int'(ack), int'(m_ack));
    check("outstanding", int'(outstanding), m_out);
    check("busy", int'(busy), int'(m_out != 0));
    check("ovf_err", int'(ovf_err), int'(m_ovf));
    check("cfg_err", int'(cfg_err), int'(m_cerr));
    check("cur_delay", int'(cur_delay), m_cur);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 0; cfg_load = 0; cfg_delay = '0; err_clr = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic add_vec(input bit r, input bit cl, input int cd, input bit ec,
                         input bit a, input int o, input bit ov, input bit ce, input int cu);
    vec_t v;
    v.r = r; v.cl = cl; v.cd = cd; v.ec = ec;
    v.ack = a; v.out = o; v.ovf = ov; v.cerr = ce; v.cur = cu;
    tbl.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, max_out;
    // ---- reset values ----
    #12;
    check("rst_ack", int'(ack), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_outstanding", int'(outstanding), 0);
    check("rst_ovf", int'(ovf_err), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_cur_delay", int'(cur_delay), DEFD);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // ---- directed table: r cl cd ec | ack out ovf cerr cur ----
    add_vec(1,0,0,0, 0,1,0,0,2);
    add_vec(0,0,0,0, 1,0,0,0,2);
    add_vec(0,0,0,0, 0,0,0,0,2);
    add_vec(1,0,0,0, 0,1,0,0,2);
    add_vec(0,0,0,0, 1,0,0,0,2);
    add_vec(0,0,0,0, 0,0,0,0,2);
    add_vec(1,0,0,0, 0,1,0,0,2);
    add_vec(0,1,5,0, 1,0,0,1,2);  // load while busy: rejected
    add_vec(0,1,5,0, 0,0,0,1,5);  // load while idle: accepted
    add_vec(1,0,0,0, 0,1,0,1,5);
    add_vec(0,0,0,0, 0,1,0,1,5);
    add_vec(0,0,0,0, 0,1,0,1,5);
    add_vec(0,0,0,0, 0,1,0,1,5);
    add_vec(0,0,0,0, 1,0,0,1,5);  // ack sampled at t+5
    add_vec(0,0,0,1, 0,0,0,0,5);
    add_vec(0,1,0,0, 0,0,0,1,5);  // delay 0 rejected
    add_vec(0,0,0,1, 0,0,0,0,5);
    add_vec(0,1,9,0, 0,0,0,1,5);  // delay 9 rejected
    add_vec(0,1,9,1, 0,0,0,1,5);  // new error beats clear
    add_vec(0,0,0,1, 0,0,0,0,5);
    add_vec(0,1,1,0, 0,0,0,0,1);
    add_vec(1,0,0,0, 1,0,0,0,1);  // D=1 direct path
    add_vec(1,0,0,0, 1,0,0,0,1);
    add_vec(0,0,0,0, 0,0,0,0,1);
    add_vec(1,0,0,0, 1,0,0,0,1);
    add_vec(0,0,0,0, 0,0,0,0,1);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].cl, tbl[i].cd, tbl[i].ec);
      check($sformatf("tbl%0d_ack", i), int'(ack), int'(tbl[i].ack));
      check($sformatf("tbl%0d_outstanding", i), int'(outstanding), tbl[i].out);
      check($sformatf("tbl%0d_ovf", i), int'(ovf_err), int'(tbl[i].ovf));
      check($sformatf("tbl%0d_cfg_err", i), int'(cfg_err), int'(tbl[i].cerr));
      check($sformatf("tbl%0d_cur_delay", i), int'(cur_delay), tbl[i].cur);
    end

    // ---- D=3, six back-to-back requests ----
    step(0, 1, 3, 0);
    check("d3_cur_delay", int'(cur_delay), 3);
    acks = 0; max_out = 0;
    for (int i = 0; i < 11; i++) begin
      step(i < 6, 0, 0, 0);
      check_model();
      acks += int'(ack);
      if (int'(outstanding) > max_out) max_out = int'(outstanding);
    end
    check("d3_ack_count", acks, 6);
    check("d3_max_outstanding", max_out, 2);
    check("d3_ovf", int'(ovf_err), 0);

    // ---- D=8, request every edge: slots overflow ----
    step(0, 1, 8, 0);
    acks = 0; max_out = 0;
    for (int i = 0; i < 20; i++) begin
      step(i < 8, 0, 0, 0);
      check_model();
      acks += int'(ack);
      if (int'(outstanding) > max_out) max_out = int'(outstanding);
    end
    check("d8_ack_count", acks, 5);
    check("d8_max_outstanding", max_out, MAXO);
    check("d8_ovf", int'(ovf_err), 1);
    step(0, 0, 0, 1);
    check("d8_ovf_cleared", int'(ovf_err), 0);

    // ---- D=4, reset asserted while a request is in flight ----
    step(0, 1, 4, 0);
    step(1, 0, 0, 0);
    check_model();
    step(0, 0, 0, 0);
    check("mid_outstanding_before_rst", int'(outstanding), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ack", int'(ack), 0);
    check("async_rst_outstanding", int'(outstanding), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_cur_delay", int'(cur_delay), DEFD);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0);
      check_model();
      acks += int'(ack);
    end
    check("post_rst_ack_count", acks, 0);

    // ---- randomized run against the reference model ----
    for (int i = 0; i < 3000; i++) begin
      int dens;
      dens = (i < 1000) ? 20 : ((i < 2000) ? 55 : 90);
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < dens, $urandom_range(0, 99) < 8,
             int'($urandom_range(0, 10)), $urandom_range(0, 99) < 6);
      end
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
